// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks.
// The FSM state type is common to every chunk-serial operator.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } adder_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface serial_adder_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple adder built from single-bit full adders.
// Also exports the carry into the top bit so the caller can detect signed overflow.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [W:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder_1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry_s[i]),
      .sum  (sum[i]),
      .c_out(carry_s[i+1])
    );
  end

  assign c_out    = carry_s[W];
  assign c_msb_in = carry_s[W-1];

endmodule

module adder_1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Chunk-serial N-bit adder: consumes CHUNK bits per clock, result after N/CHUNK steps.
// Operands and results move through valid/ready handshakes on serial_adder_if.
module serial_adder
  import adder_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int STEPS = N / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_adder: N (%0d) must be a multiple of CHUNK (%0d)", N, CHUNK);
  end
  if ($bits(bus.a) != N) begin : g_bad_bus
    $error("serial_adder: interface width does not match N (%0d)", N);
  end

  adder_state_t   state_r;
  adder_state_t   state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           carry_r;
  logic [N-1:0]   sum_r;
  logic           c_out_r;
  logic           ovf_r;

  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_c_s;
  logic             chunk_msb_s;
  logic [N-1:0]     acc_nxt_s;
  logic             last_step_s;

  assign last_step_s = (cnt_r == LAST_CNT);

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a       (a_r[CHUNK-1:0]),
    .b       (b_r[CHUNK-1:0]),
    .c_in    (carry_r),
    .sum     (chunk_sum_s),
    .c_out   (chunk_c_s),
    .c_msb_in(chunk_msb_s)
  );

  // Partial sums enter from the MSB side, so after the last step the word is in place.
  if (STEPS == 1) begin : g_single
    assign acc_nxt_s = chunk_sum_s;
  end else begin : g_multi
    logic [N-CHUNK-1:0] acc_r;

    // Accumulator of the chunks produced so far
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_r <= {(N-CHUNK){1'b0}};
      end else if (state_r == S_BUSY) begin
        acc_r <= acc_nxt_s[N-1:CHUNK];
      end else begin
        acc_r <= acc_r;
      end
    end

    assign acc_nxt_s = {chunk_sum_s, acc_r};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nxt_s = S_BUSY;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_step_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand shift registers, step counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CW{1'b0}};
      a_r     <= {N{1'b0}};
      b_r     <= {N{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {N{1'b0}};
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.c_in;
            cnt_r   <= {CW{1'b0}};
          end
        end
        S_BUSY: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry_r <= chunk_c_s;
          if (last_step_s) begin
            cnt_r   <= {CW{1'b0}};
            sum_r   <= acc_nxt_s;
            c_out_r <= chunk_c_s;
            ovf_r   <= chunk_c_s ^ chunk_msb_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == S_IDLE);
  assign bus.out_valid = (state_r == S_DONE);
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: N=8/CHUNK=2 directed + random, N=32/CHUNK=4 and
// N=8/CHUNK=8 random sweeps, each result checked against a plain-arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst8;
  logic rst_r;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  serial_adder_if #(.N(8))  if8  ();
  serial_adder_if #(.N(32)) if32 ();
  serial_adder_if #(.N(8))  if88 ();

  serial_adder #(.N(8),  .CHUNK(2)) dut8  (.clk(clk), .rst(rst8),  .bus(if8.slave));
  serial_adder #(.N(32), .CHUNK(4)) dut32 (.clk(clk), .rst(rst_r), .bus(if32.slave));
  serial_adder #(.N(8),  .CHUNK(8)) dut88 (.clk(clk), .rst(rst_r), .bus(if88.slave));

  // scoreboard state per instance: 0 = n8c2, 1 = n32c4, 2 = n8c8
  logic [33:0] expq [3][$];
  int          accq [3][$];
  bit          pend [3];
  logic [33:0] held [3];
  bit bp8 = 1'b0;
  bit done32 = 1'b0;
  bit done88 = 1'b0;

  // reference: {ovf, c_out, sum} from integer arithmetic
  function automatic logic [33:0] ref_add(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    longint mask, ua, ub, us, sa, sb, ss, half;
    logic [33:0] r;
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    us = ua + ub + longint'(cin);
    sa = (ua >= half) ? ua - (longint'(1) << n) : ua;
    sb = (ub >= half) ? ub - (longint'(1) << n) : ub;
    ss = sa + sb + longint'(cin);
    r = '0;
    r[31:0] = 32'(us & mask);
    r[32]   = ((us >> n) & 1) != 0;
    r[33]   = (ss > half - 1) || (ss < -half);
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic flag_fail(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic mon(input int id, input string nm, input logic in_rst, input logic vld,
                     input logic rdy, input logic [33:0] got, input int steps);
    logic [33:0] e;
    int t;
    if (in_rst) begin
      pend[id] = 1'b0;
    end else if (vld) begin
      if (!pend[id]) begin
        if (expq[id].size() == 0) begin
          flag_fail({nm, "_spurious_out_valid"});
        end else begin
          e = expq[id].pop_front();
          t = accq[id].pop_front();
          check({nm, "_latency"}, 64'(cyc - t), 64'(steps));
          check({nm, "_result_ovf_cout_sum"}, 64'(got), 64'(e));
        end
        pend[id] = 1'b1;
        held[id] = got;
      end else begin
        check({nm, "_stall_stable"}, 64'(got), 64'(held[id]));
      end
      if (rdy) pend[id] = 1'b0;
    end
  endtask

  // monitor: sample all instances on the falling edge
  always @(negedge clk) begin
    mon(0, "n8c2",  rst8,  if8.out_valid,  if8.out_ready,  {if8.ovf,  if8.c_out,  24'd0, if8.sum},  4);
    mon(1, "n32c4", rst_r, if32.out_valid, if32.out_ready, {if32.ovf, if32.c_out, if32.sum},        8);
    mon(2, "n8c8",  rst_r, if88.out_valid, if88.out_ready, {if88.ovf, if88.c_out, 24'd0, if88.sum}, 1);
  end

  // random consumer backpressure, changed well away from both edges
  always @(posedge clk) begin
    #2;
    if (bp8) if8.out_ready = ($urandom_range(0, 3) != 0);
    if32.out_ready = ($urandom_range(0, 3) != 0);
    if88.out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int n = 0;
    if8.a = a; if8.b = b; if8.c_in = cin; if8.in_valid = 1'b1;
    while (!if8.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!if8.in_ready) flag_fail("n8c2_accept_timeout");
    else begin
      expq[0].push_back(ref_add(8, {24'd0, a}, {24'd0, b}, cin));
      accq[0].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int n = 0;
    if32.a = a; if32.b = b; if32.c_in = cin; if32.in_valid = 1'b1;
    while (!if32.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!if32.in_ready) flag_fail("n32c4_accept_timeout");
    else begin
      expq[1].push_back(ref_add(32, a, b, cin));
      accq[1].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
  endtask

  task automatic issue88(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int n = 0;
    if88.a = a; if88.b = b; if88.c_in = cin; if88.in_valid = 1'b1;
    while (!if88.in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!if88.in_ready) flag_fail("n8c8_accept_timeout");
    else begin
      expq[2].push_back(ref_add(8, {24'd0, a}, {24'd0, b}, cin));
      accq[2].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    if88.in_valid = 1'b0;
  endtask

  task automatic drain(input int id, input string nm);
    int n = 0;
    while ((expq[id].size() != 0 || pend[id]) && n < 400) begin @(posedge clk); #1; n++; end
    if (expq[id].size() != 0 || pend[id]) flag_fail({nm, "_drain_timeout"});
  endtask

  task automatic check_idle8(input string nm, input logic [7:0] sum_exp, input logic [1:0] flags_exp);
    check({nm, "_ready_valid"}, 64'({if8.in_ready, if8.out_valid}), 64'(2'b10));
    check({nm, "_sum"}, 64'(if8.sum), 64'(sum_exp));
    check({nm, "_ovf_cout"}, 64'({if8.ovf, if8.c_out}), 64'(flags_exp));
  endtask

  // wide and single-step instances: random sweep with corner vectors up front
  initial begin
    rst_r = 1'b1;
    if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.c_in = 1'b0; if32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_r = 1'b0;
    fork
      begin
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue32(32'h8000_0000, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 1000; i++) begin
          issue32($urandom(), $urandom(), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        drain(1, "n32c4");
        done32 = 1'b1;
      end
      begin
        issue88(8'hFF, 8'hFF, 1'b1);
        issue88(8'h7F, 8'h00, 1'b1);
        issue88(8'h80, 8'hFF, 1'b0);
        for (int i = 0; i < 1000; i++) begin
          issue88(8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        drain(2, "n8c8");
        done88 = 1'b1;
      end
    join
  end

  initial begin
    if88.in_valid = 1'b0; if88.a = '0; if88.b = '0; if88.c_in = 1'b0; if88.out_ready = 1'b1;
  end

  // directed sequence on the N=8/CHUNK=2 instance, then the final summary
  initial begin
    int n;
    rst8 = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0; if8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0;
    check_idle8("reset", 8'h00, 2'b00);

    issue8(8'h0F, 8'h01, 1'b0); drain(0, "n8c2");
    issue8(8'hFF, 8'h01, 1'b0); drain(0, "n8c2");
    issue8(8'h00, 8'h00, 1'b1); drain(0, "n8c2");
    issue8(8'h7F, 8'h01, 1'b0); drain(0, "n8c2");
    issue8(8'h80, 8'h80, 1'b0); drain(0, "n8c2");
    issue8(8'hFF, 8'hFF, 1'b1); drain(0, "n8c2");
    check_idle8("retain_after_handoff", 8'hFF, 2'b01);

    // backpressure with new operands offered during the stall
    if8.out_ready = 1'b0;
    issue8(8'h12, 8'h34, 1'b0);
    n = 0;
    while (!if8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!if8.out_valid) flag_fail("bp_out_valid_timeout");
    if8.a = 8'hAA; if8.b = 8'h55; if8.c_in = 1'b1; if8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ready_valid", 64'({if8.in_ready, if8.out_valid}), 64'(2'b01));
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle8("bp_release", 8'h46, 2'b00);
    issue8(8'hAA, 8'h55, 1'b1); drain(0, "n8c2");

    // reset two steps into an addition
    issue8(8'h5A, 8'h3C, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b1;
    expq[0].delete(); accq[0].delete();
    @(posedge clk); #1 rst8 = 1'b0;
    check_idle8("mid_busy_reset", 8'h00, 2'b00);
    issue8(8'h3C, 8'h44, 1'b0); drain(0, "n8c2");

    // random with random backpressure
    bp8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue8(8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain(0, "n8c2");

    n = 0;
    while (!(done32 && done88) && n < 60000) begin @(posedge clk); n++; end
    if (!(done32 && done88)) flag_fail("random_sweep_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
